// File: rtl/ecc_io_pkg.sv
// Shared state type, sizing helpers and default widths for the ECC core digit-serial front end.
package ecc_io_pkg;

    localparam int unsigned EccWidth  = 32;
    localparam int unsigned EccDigitW = 4;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StUnload
    } state_e;

    function automatic int unsigned ndig(input int unsigned width, input int unsigned digit_w);
        return width / digit_w;
    endfunction

    // Counter width for n values, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/ecc_digit_shifter.sv
// WIDTH-bit register with indexed digit write, full-word load and indexed digit read.
module ecc_digit_shifter
    import ecc_io_pkg::*;
#(
    parameter int unsigned WIDTH   = EccWidth,
    parameter int unsigned DIGIT_W = EccDigitW,
    localparam int unsigned NDIG   = ndig(WIDTH, DIGIT_W),
    localparam int unsigned CW     = cnt_w(NDIG)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_wr_en,
    input  logic [CW-1:0]      i_wr_idx,
    input  logic [DIGIT_W-1:0] i_wr_digit,
    input  logic               i_ld_en,
    input  logic [WIDTH-1:0]   i_ld_word,
    input  logic [CW-1:0]      i_rd_idx,
    output logic [DIGIT_W-1:0] o_rd_digit,
    output logic [WIDTH-1:0]   o_word
);

    logic [WIDTH-1:0] r_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_word <= '0;
        end else if (i_ld_en) begin
            r_word <= i_ld_word;
        end else if (i_wr_en) begin
            for (int unsigned i = 0; i < NDIG; i++) begin
                if (i_wr_idx == CW'(i)) begin
                    r_word[i*DIGIT_W +: DIGIT_W] <= i_wr_digit;
                end
            end
        end
    end

    always_comb begin
        o_rd_digit = '0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (i_rd_idx == CW'(i)) begin
                o_rd_digit = r_word[i*DIGIT_W +: DIGIT_W];
            end
        end
    end

    assign o_word = r_word;

endmodule

// File: rtl/ecc_digit_io.sv
// Digit-serial operand loader, core launcher with watchdog, and flow-controlled result unloader.
module ecc_digit_io
    import ecc_io_pkg::*;
#(
    parameter int unsigned WIDTH   = EccWidth,
    parameter int unsigned DIGIT_W = EccDigitW,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               in_start,
    input  logic [DIGIT_W-1:0] in_a,
    input  logic [DIGIT_W-1:0] in_prime,
    input  logic [DIGIT_W-1:0] in_px,
    input  logic [DIGIT_W-1:0] in_py,
    input  logic [DIGIT_W-1:0] in_k,
    output logic               in_ready,
    output logic               core_start,
    output logic [WIDTH-1:0]   core_a,
    output logic [WIDTH-1:0]   core_prime,
    output logic [WIDTH-1:0]   core_px,
    output logic [WIDTH-1:0]   core_py,
    output logic [WIDTH-1:0]   core_k,
    input  logic               core_done,
    input  logic [WIDTH-1:0]   core_kpx,
    input  logic [WIDTH-1:0]   core_kpy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DIGIT_W-1:0] out_kpx,
    output logic [DIGIT_W-1:0] out_kpy,
    output logic               out_last,
    output logic               busy,
    output logic               error
);

    localparam int unsigned NDIG = ndig(WIDTH, DIGIT_W);
    localparam int unsigned CW   = cnt_w(NDIG);
    localparam int unsigned WDW  = cnt_w(TIMEOUT + 1);

    localparam logic [CW-1:0]  LastIdx = CW'(NDIG - 1);
    localparam logic [CW-1:0]  CntOne  = CW'(1);
    localparam logic [WDW-1:0] WdLast  = WDW'(TIMEOUT - 1);

    state_e         r_state;
    logic [CW-1:0]  r_cnt;
    logic [WDW-1:0] r_wd;
    logic           r_error;
    logic           r_core_start;
    logic           r_out_valid;
    logic           r_in_ready;
    logic           r_busy;

    logic           w_take_first;
    logic           w_take_load;
    logic           w_op_we;
    logic [CW-1:0]  w_op_idx;
    logic           w_res_ld;
    logic           w_out_fire;

    assign w_take_first = (r_state == StIdle) && in_valid && in_start;
    assign w_take_load  = (r_state == StLoad) && in_valid;
    assign w_op_we      = w_take_first || w_take_load;
    assign w_op_idx     = w_take_first ? '0 : r_cnt;
    assign w_res_ld     = (r_state == StRun) && core_done;
    assign w_out_fire   = r_out_valid && out_ready;

    logic [DIGIT_W-1:0] w_op_digit [5];
    logic [WIDTH-1:0]   w_op_word [5];
    logic [DIGIT_W-1:0] w_unused_op_rd [5];
    logic [WIDTH-1:0]   w_unused_res_word [2];

    assign w_op_digit[0] = in_a;
    assign w_op_digit[1] = in_prime;
    assign w_op_digit[2] = in_px;
    assign w_op_digit[3] = in_py;
    assign w_op_digit[4] = in_k;

    for (genvar g = 0; g < 5; g++) begin : g_op
        ecc_digit_shifter #(
            .WIDTH   (WIDTH),
            .DIGIT_W (DIGIT_W)
        ) u_op (
            .clk        (clk),
            .reset      (reset),
            .i_wr_en    (w_op_we),
            .i_wr_idx   (w_op_idx),
            .i_wr_digit (w_op_digit[g]),
            .i_ld_en    (1'b0),
            .i_ld_word  ('0),
            .i_rd_idx   ('0),
            .o_rd_digit (w_unused_op_rd[g]),
            .o_word     (w_op_word[g])
        );
    end

    assign core_a     = w_op_word[0];
    assign core_prime = w_op_word[1];
    assign core_px    = w_op_word[2];
    assign core_py    = w_op_word[3];
    assign core_k     = w_op_word[4];

    ecc_digit_shifter #(
        .WIDTH   (WIDTH),
        .DIGIT_W (DIGIT_W)
    ) u_res_kpx (
        .clk        (clk),
        .reset      (reset),
        .i_wr_en    (1'b0),
        .i_wr_idx   ('0),
        .i_wr_digit ('0),
        .i_ld_en    (w_res_ld),
        .i_ld_word  (core_kpx),
        .i_rd_idx   (r_cnt),
        .o_rd_digit (out_kpx),
        .o_word     (w_unused_res_word[0])
    );

    ecc_digit_shifter #(
        .WIDTH   (WIDTH),
        .DIGIT_W (DIGIT_W)
    ) u_res_kpy (
        .clk        (clk),
        .reset      (reset),
        .i_wr_en    (1'b0),
        .i_wr_idx   ('0),
        .i_wr_digit ('0),
        .i_ld_en    (w_res_ld),
        .i_ld_word  (core_kpy),
        .i_rd_idx   (r_cnt),
        .o_rd_digit (out_kpy),
        .o_word     (w_unused_res_word[1])
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_wd         <= '0;
            r_error      <= 1'b0;
            r_core_start <= 1'b0;
            r_out_valid  <= 1'b0;
            r_in_ready   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_core_start <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    r_in_ready <= 1'b1;
                    if (w_take_first) begin
                        r_error <= 1'b0;
                        r_busy  <= 1'b1;
                        // A single-digit word is complete as soon as digit 0 lands.
                        if (NDIG == 1) begin
                            r_state      <= StRun;
                            r_core_start <= 1'b1;
                            r_wd         <= '0;
                            r_in_ready   <= 1'b0;
                        end else begin
                            r_state <= StLoad;
                            r_cnt   <= CntOne;
                        end
                    end
                end
                StLoad: begin
                    if (w_take_load) begin
                        if (r_cnt == LastIdx) begin
                            r_state      <= StRun;
                            r_core_start <= 1'b1;
                            r_wd         <= '0;
                            r_in_ready   <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + CntOne;
                        end
                    end
                end
                StRun: begin
                    // core_done takes priority over an expiring watchdog.
                    if (core_done) begin
                        r_state     <= StUnload;
                        r_cnt       <= '0;
                        r_out_valid <= 1'b1;
                    end else if (r_wd == WdLast) begin
                        r_state    <= StIdle;
                        r_error    <= 1'b1;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b0;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                StUnload: begin
                    if (w_out_fire) begin
                        if (r_cnt == LastIdx) begin
                            r_state     <= StIdle;
                            r_cnt       <= '0;
                            r_out_valid <= 1'b0;
                            r_in_ready  <= 1'b1;
                            r_busy      <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + CntOne;
                        end
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign core_start = r_core_start;
    assign out_valid  = r_out_valid;
    assign out_last   = r_out_valid && (r_cnt == LastIdx);
    assign busy       = r_busy;
    assign error      = r_error;

endmodule

// File: tb/tb_ecc_digit_io.sv
// Scoreboard bench for ecc_digit_io: 32/4 instance with stub core plus an 8/8 single-digit instance.
module tb_ecc_digit_io;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] p;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] k;
    } ops_t;

    typedef struct packed {
        logic [3:0] kpx;
        logic [3:0] kpy;
        logic       last;
    } dig_t;

    logic        clk;
    logic        reset;
    logic        in_valid, in_start;
    logic [3:0]  in_a, in_prime, in_px, in_py, in_k;
    logic        in_ready, core_start;
    logic [31:0] core_a, core_prime, core_px, core_py, core_k;
    logic        core_done;
    logic [31:0] core_kpx, core_kpy;
    logic        out_valid, out_ready, out_last, busy, error;
    logic [3:0]  out_kpx, out_kpy;

    logic        in_valid8, in_start8;
    logic [7:0]  in_a8, in_prime8, in_px8, in_py8, in_k8;
    logic        in_ready8, core_start8;
    logic [7:0]  core_a8, core_prime8, core_px8, core_py8, core_k8;
    logic        core_done8;
    logic [7:0]  core_kpx8, core_kpy8;
    logic        out_valid8, out_ready8, out_last8, busy8, error8;
    logic [7:0]  out_kpx8, out_kpy8;

    ecc_digit_io #(.WIDTH(32), .DIGIT_W(4), .TIMEOUT(20)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_start(in_start),
        .in_a(in_a), .in_prime(in_prime), .in_px(in_px), .in_py(in_py), .in_k(in_k),
        .in_ready(in_ready), .core_start(core_start),
        .core_a(core_a), .core_prime(core_prime), .core_px(core_px), .core_py(core_py),
        .core_k(core_k), .core_done(core_done), .core_kpx(core_kpx), .core_kpy(core_kpy),
        .out_valid(out_valid), .out_ready(out_ready), .out_kpx(out_kpx), .out_kpy(out_kpy),
        .out_last(out_last), .busy(busy), .error(error)
    );

    ecc_digit_io #(.WIDTH(8), .DIGIT_W(8), .TIMEOUT(20)) u_dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_start(in_start8),
        .in_a(in_a8), .in_prime(in_prime8), .in_px(in_px8), .in_py(in_py8), .in_k(in_k8),
        .in_ready(in_ready8), .core_start(core_start8),
        .core_a(core_a8), .core_prime(core_prime8), .core_px(core_px8), .core_py(core_py8),
        .core_k(core_k8), .core_done(core_done8), .core_kpx(core_kpx8), .core_kpy(core_kpy8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_kpx(out_kpx8), .out_kpy(out_kpy8),
        .out_last(out_last8), .busy(busy8), .error(error8)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   start_seen = 0;
    int   t_start = 0;
    bit   stub_en = 1;
    bit   bp_mode = 0;
    int   n_xfer = 0;
    ops_t opq[$];
    dig_t sbq[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Stub core: answers two cycles after launch when enabled.
    initial begin
        core_done = 1'b0;
        core_kpx  = 32'h12345678;
        core_kpy  = 32'h9ABCDEF0;
        forever begin
            @(negedge clk);
            if (core_start && stub_en) begin
                repeat (2) @(posedge clk);
                #1 core_done = 1'b1;
                @(posedge clk);
                #1 core_done = 1'b0;
            end
        end
    end

    initial begin
        int       k;
        bit [3:0] pat;
        k = 0;
        pat = 4'b1001;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                out_ready = pat[k % 4];
                k++;
            end else begin
                out_ready = 1'b1;
                k = 0;
            end
        end
    end

    // Monitor: launch words, output digits, and hold behaviour under backpressure.
    initial begin
        bit   stalled;
        dig_t held, cur, exp;
        ops_t eo;
        stalled = 0;
        held = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stalled = 0;
            end else begin
                cur = {out_kpx, out_kpy, out_last};
                if (stalled) check("hold", {out_valid, cur}, {1'b1, held});
                if (core_start) begin
                    start_seen = 1;
                    t_start = cyc;
                    if (opq.size() == 0) begin
                        flag("unexpected core_start");
                    end else begin
                        eo = opq.pop_front();
                        check("core_a", core_a, eo.a);
                        check("core_prime", core_prime, eo.p);
                        check("core_px", core_px, eo.x);
                        check("core_py", core_py, eo.y);
                        check("core_k", core_k, eo.k);
                    end
                end
                if (out_valid && out_ready) begin
                    n_xfer++;
                    if (sbq.size() == 0) begin
                        flag("unexpected out digit");
                    end else begin
                        exp = sbq.pop_front();
                        check("out_digit", cur, exp);
                    end
                end
                stalled = out_valid && !out_ready;
                held = cur;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global timeout");
        $fatal(1, "bench timeout");
    end

    task automatic send_ops(input ops_t o, input int n_send, input int stall_after,
                            input int stall_len);
        for (int i = 0; i < n_send; i++) begin
            in_valid = 1'b1;
            in_start = (i == 0);
            in_a     = o.a[i*4 +: 4];
            in_prime = o.p[i*4 +: 4];
            in_px    = o.x[i*4 +: 4];
            in_py    = o.y[i*4 +: 4];
            in_k     = o.k[i*4 +: 4];
            @(posedge clk);
            #1;
            if (i == stall_after) begin
                in_valid = 1'b0;
                repeat (stall_len) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        in_valid = 1'b0;
        in_start = 1'b0;
    endtask

    task automatic wait_start();
        for (int i = 0; i < 30 && !start_seen; i++) begin
            @(negedge clk);
            #1;
        end
        if (!start_seen) flag("core_start never seen");
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while ((busy || sbq.size() != 0) && i < 100) begin
            @(negedge clk);
            #1;
            i++;
        end
        if (i >= 100) flag("unload did not finish");
    endtask

    task automatic run_job(input ops_t o, input int stall_after, input int stall_len,
                           input int exp_delay);
        int          t0;
        logic [31:0] kx, ky;
        kx = 32'h12345678;
        ky = 32'h9ABCDEF0;
        opq.push_back(o);
        for (int i = 0; i < 8; i++) sbq.push_back({kx[i*4 +: 4], ky[i*4 +: 4], i == 7});
        start_seen = 0;
        n_xfer = 0;
        t0 = cyc;
        send_ops(o, 8, stall_after, stall_len);
        wait_start();
        check("start_delay", 64'(t_start - t0), 64'(exp_delay));
        wait_idle();
        check("transfers", 64'(n_xfer), 64'd8);
        @(posedge clk);
        #1;
    endtask

    initial begin
        ops_t ops1, ops2, junk;
        ops1 = '{32'h00000002, 32'h00000061, 32'h00000003, 32'h00000006, 32'h00000005};
        ops2 = '{32'h0BADF00D, 32'hFFFFFFFB, 32'h13579BDF, 32'h87654321, 32'hDEADBEEF};
        junk = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        reset = 1'b1;
        {in_valid, in_start, in_a, in_prime, in_px, in_py, in_k} = '0;
        {in_valid8, in_start8, in_a8, in_prime8, in_px8, in_py8, in_k8} = '0;
        core_done8 = 1'b0;
        core_kpx8 = 8'h3C;
        core_kpy8 = 8'hC3;
        out_ready8 = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst in_ready", in_ready, 0);
        check("rst core_start", core_start, 0);
        check("rst out_valid", out_valid, 0);
        check("rst out_last", out_last, 0);
        check("rst out_digits", {out_kpx, out_kpy}, 0);
        check("rst busy", busy, 0);
        check("rst error", error, 0);
        check("rst core_words", {core_a, core_prime, core_px, core_py, core_k}, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("idle in_ready", in_ready, 1);
        check("idle busy", busy, 0);

        // Stray digit without in_start in IDLE must be dropped, then a clean load.
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_a = 4'hF;
        in_k = 4'hF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("stray busy", busy, 0);
        @(posedge clk);
        #1;
        run_job(ops1, -1, 0, 8);
        check("error after job", error, 0);

        run_job(ops1, 4, 3, 11);

        bp_mode = 1;
        run_job(ops1, -1, 0, 8);
        bp_mode = 0;

        // Watchdog: stub silent, TIMEOUT=20.
        stub_en = 0;
        opq.push_back(ops1);
        start_seen = 0;
        send_ops(ops1, 8, -1, 0);
        wait_start();
        repeat (19) @(posedge clk);
        @(negedge clk);
        check("wd error early", error, 0);
        check("wd busy early", busy, 1);
        @(posedge clk);
        @(negedge clk);
        check("wd error", error, 1);
        check("wd busy", busy, 0);
        check("wd in_ready", in_ready, 1);
        stub_en = 1;
        @(posedge clk);
        #1;
        run_job(ops2, -1, 0, 8);
        check("error cleared", error, 0);

        // Reset after digit 3 of a load discards the partial operands.
        send_ops(junk, 4, -1, 0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid reset busy", busy, 0);
        check("mid reset core_a", core_a, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        run_job(ops2, -1, 0, 8);

        // Single-digit instance.
        in_valid8 = 1'b1;
        in_start8 = 1'b1;
        {in_a8, in_prime8, in_px8, in_py8, in_k8} = {8'hA5, 8'h61, 8'h03, 8'h06, 8'h05};
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        in_start8 = 1'b0;
        @(negedge clk);
        check("n1 core_start", core_start8, 1);
        check("n1 words", {core_a8, core_prime8, core_px8, core_py8, core_k8},
              {8'hA5, 8'h61, 8'h03, 8'h06, 8'h05});
        @(posedge clk);
        #1 core_done8 = 1'b1;
        @(posedge clk);
        #1 core_done8 = 1'b0;
        @(negedge clk);
        check("n1 out", {out_valid8, out_last8, out_kpx8, out_kpy8}, {2'b11, 8'h3C, 8'hC3});
        @(posedge clk);
        @(negedge clk);
        check("n1 done", {out_valid8, busy8, error8}, 0);

        check("opq empty", 64'(opq.size()), 0);
        check("sbq empty", 64'(sbq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ecc_digit_io.md
# ecc_digit_io

Parametrised digit-serial front end for the ECC scalar-multiply core. It assembles the operands a, prime, Px, Py and k from DIGIT_W-bit digits into WIDTH-bit words and launches the core with a one-cycle start. It then captures kPx/kPy and returns them digit-serially under ready/valid backpressure. It replaces the fixed 4-bit/32-bit, no-flow-control serial wrapper in front of the core and adds stall, backpressure and a watchdog.

## Interface
- WIDTH, 32: operand/result width in bits; must be a multiple of DIGIT_W.
- DIGIT_W, 4: serial digit width.
- TIMEOUT, 65535: maximum core cycles from core_start to core_done before error.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  current input digits valid.
- in_start  in  1  marks digit 0 of a new operand set; sampled only with in_valid.
- in_a, in_prime, in_px, in_py, in_k  in  DIGIT_W each  operand digits, LSB digit first.
- in_ready  out  1  high only in IDLE and LOAD.
- core_start  out  1  one-cycle launch pulse.
- core_a, core_prime, core_px, core_py, core_k  out  WIDTH each  assembled operands; stable from core_start until next load.
- core_done  in  1  core result valid, sampled only in RUN.
- core_kpx, core_kpy  in  WIDTH each  core result.
- out_valid  out  1  result digit valid.
- out_ready  in  1  consumer accepts digit.
- out_kpx, out_kpy  out  DIGIT_W each  result digits, LSB digit first.
- out_last  out  1  with out_valid on final digit.
- busy  out  1  state != IDLE.
- error  out  1  sticky watchdog flag; cleared only by reset or next accepted in_start.

## Operation
- NDIG = WIDTH/DIGIT_W; digit counter width clog2(NDIG), minimum 1.
- States: IDLE, LOAD, RUN, UNLOAD.
- IDLE: in_valid & in_start writes digit 0 into bits [DIGIT_W-1:0] of all five operand registers, clears error, cnt=1, goes to LOAD; if NDIG==1 goes directly to LAUNCH behaviour (RUN with core_start). in_valid without in_start is dropped.
- LOAD: each in_valid cycle writes digit cnt into bits [cnt*DIGIT_W +: DIGIT_W]; in_valid low stalls with no change. in_start during LOAD is ignored (treated as data). On digit NDIG-1 accepted: core_start=1 next cycle, state RUN, watchdog cleared.
- RUN: watchdog increments each cycle. core_done=1 latches core_kpx/core_kpy, cnt=0, state UNLOAD. Watchdog reaching TIMEOUT without core_done: error=1, state IDLE, no output produced.
- UNLOAD: out_valid=1, out_kpx/out_kpy = latched result digit cnt; out_last = (cnt==NDIG-1). On out_valid & out_ready cnt increments; on last digit accepted state IDLE. out_ready low holds digit and out_valid.
- core_done outside RUN ignored; core_done in the same cycle the watchdog expires: done wins, no error.
- Reset mid-operation: immediate return to IDLE, partial operands discarded.

## Timing
- Reset values: in_ready=0 during reset then 1 in IDLE; core_start=0, out_valid=0, out_last=0, out_kpx/out_kpy=0, busy=0, error=0, core_* operand outputs=0.
- Load latency: NDIG accepted in_valid cycles; core_start asserted the cycle after the last accepted digit.
- core_done sampled at edge N → out_valid high from edge N+1.
- Unload: NDIG cycles with out_ready held high; minimum end-to-end overhead excluding core = NDIG + 1 + 1 + NDIG cycles.
- All outputs registered; no combinational path from in_* or core_done to outputs, except out_* hold on out_ready low, which uses registered state only.

## Structure
- Package ecc_io_pkg: state enum (IDLE, LOAD, RUN, UNLOAD), NDIG and counter-width functions, default WIDTH/DIGIT_W constants shared with the core.
- Sub-module ecc_digit_shifter: parametrised WIDTH/DIGIT_W register with indexed digit write and indexed digit read; instantiated for the five operands (write side) and two results (read side).

## Test plan
- WIDTH=32, DIGIT_W=4, a=0x00000002, prime=0x00000061, Px=0x00000003, Py=0x00000006, k=0x00000005 sent in 8 back-to-back digits -> core_start one cycle after digit 7; core_* words equal the stimulus; stub core returns kPx=0x12345678, kPy=0x9ABCDEF0 -> out digits 8,7,6,...,1 and 0,F,E,...,9, out_last on the 8th.
- Same load with in_valid low for 3 cycles after digit 4 -> identical core words; core_start delayed exactly 3 cycles.
- out_ready toggling 1,0,0,1 during unload -> each digit held while out_ready=0; no digit skipped or repeated; 8 transfers total.
- TIMEOUT=20, stub core never asserts done -> error=1 at cycle 20 after core_start, state IDLE, out_valid never asserted; next in_start clears error.
- Reset asserted after digit 3 of a load -> busy=0 next cycle; a fresh 8-digit load then produces correct core words with no leftover digits.
- WIDTH=8, DIGIT_W=8 (NDIG=1): single digit with in_start -> core_start next cycle; single output digit with out_last=1.
